// File: rtl/sha3_pkg.sv
// sha3_pkg: constants, packer state and rate-block type shared by the SHA3-256 datapath.
package sha3_pkg;
   localparam int LANE_W     = 64;
   localparam int RATE_LANES = 17;
   localparam int STATE_W    = 1600;
   localparam logic [7:0] PAD_DOMAIN = 8'h06;
   localparam logic [7:0] PAD_FINAL  = 8'h80;
   typedef enum logic [1:0] {FILL, HOLD, PADBLK} packer_state_e;
   typedef logic [RATE_LANES-1:0][LANE_W-1:0] rate_blk_t;
   function automatic rate_blk_t pad_block();
      rate_blk_t r;
      r = '0;
      r[0][7:0] = PAD_DOMAIN;
      r[RATE_LANES-1][LANE_W-1 -: 8] = PAD_FINAL;
      return r;
   endfunction
endpackage

// File: rtl/sha3_input_packer_if.sv
// sha3_input_packer_if: message-word source and block sink signals of the input packer.
interface sha3_input_packer_if;
   import sha3_pkg::*;
   logic               pushin;
   logic               firstin;
   logic               lastin;
   logic [3:0]         nbytes;
   logic [LANE_W-1:0]  din;
   logic [7:0]         tagin;
   logic               stopin;
   logic               busyin;
   logic               pushout;
   logic [STATE_W-1:0] dout;
   logic               firstout;
   logic               lastout;
   logic [7:0]         tagout;
   modport slave (
      input  pushin, firstin, lastin, nbytes, din, tagin, busyin,
      output stopin, pushout, dout, firstout, lastout, tagout
   );
   modport master (
      output pushin, firstin, lastin, nbytes, din, tagin, busyin,
      input  stopin, pushout, dout, firstout, lastout, tagout
   );
endinterface

// File: rtl/sha3_pad_lane.sv
// sha3_pad_lane: zero bytes past nbytes, then XOR in the domain and/or final pad bytes.
module sha3_pad_lane
   import sha3_pkg::*;
(
   input  logic [LANE_W-1:0] word_i,
   input  logic [3:0]        nbytes_i,
   input  logic              pad_first_i,
   input  logic              pad_final_i,
   output logic [LANE_W-1:0] lane_o
);
   always_comb begin
      lane_o = '0;
      for (int b = 0; b < 8; b++)
         lane_o[8*b +: 8] = ((4'(b) < nbytes_i) ? word_i[8*b +: 8] : 8'h00) ^
                            ((pad_first_i && 4'(b) == nbytes_i) ? PAD_DOMAIN : 8'h00);
      lane_o[LANE_W-1 -: 8] = lane_o[LANE_W-1 -: 8] ^ (pad_final_i ? PAD_FINAL : 8'h00);
   end
endmodule

// File: rtl/sha3_input_packer.sv
// sha3_input_packer: packs 64-bit message words into padded SHA3-256 rate blocks
// and holds each block until the permutation core accepts it.
module sha3_input_packer
   import sha3_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   sha3_input_packer_if.slave  bus
);
   localparam logic [4:0] LAST = 5'(RATE_LANES - 1);
   packer_state_e     state_q, state_d;
   rate_blk_t         blk_q, blk_d, base;
   logic [4:0]        lane_q, lane_d, cur;
   logic              first_pend_q, first_pend_d, pad_pend_q, pad_pend_d;
   logic              firstout_q, firstout_d, lastout_q, lastout_d;
   logic [7:0]        tag_q, tag_d, tagout_q, tagout_d;
   logic              accept, complete, spill, xfer;
   logic [LANE_W-1:0] data_lane;
   assign accept   = bus.pushin && state_q == FILL;
   assign cur      = bus.firstin ? 5'd0 : lane_q;
   // a full last word in the final lane leaves no room for padding: it needs its own block
   assign spill    = bus.lastin && bus.nbytes == 4'd8 && cur == LAST;
   assign complete = accept && (bus.lastin || cur == LAST);
   assign xfer     = state_q != FILL && !bus.busyin;
   sha3_pad_lane u_pad (
      .word_i      (bus.din),
      .nbytes_i    (bus.nbytes),
      .pad_first_i (bus.lastin && bus.nbytes < 4'd8),
      .pad_final_i (bus.lastin && cur == LAST && bus.nbytes < 4'd8),
      .lane_o      (data_lane)
   );
   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      lane_d       = lane_q;
      first_pend_d = first_pend_q;
      pad_pend_d   = pad_pend_q;
      firstout_d   = firstout_q;
      lastout_d    = lastout_q;
      tagout_d     = tagout_q;
      tag_d        = (accept && bus.firstin) ? bus.tagin : tag_q;
      base         = bus.firstin ? '0 : blk_q;
      if (xfer) begin
         state_d    = pad_pend_q ? PADBLK : FILL;
         blk_d      = pad_pend_q ? pad_block() : '0;
         lastout_d  = pad_pend_q;
         firstout_d = 1'b0;
         pad_pend_d = 1'b0;
      end else if (accept) begin
         for (int j = 0; j < RATE_LANES; j++)
            blk_d[j] = (5'(j) == cur) ? data_lane :
                       (bus.lastin && 5'(j) > cur) ?
                          {(j == RATE_LANES - 1) ? PAD_FINAL : 8'h00, 48'h0,
                           (5'(j) == cur + 5'd1 && bus.nbytes == 4'd8) ? PAD_DOMAIN : 8'h00} :
                       base[j];
         lane_d       = complete ? 5'd0 : cur + 5'd1;
         first_pend_d = (first_pend_q || bus.firstin) && !complete;
         if (complete) begin
            state_d    = HOLD;
            firstout_d = first_pend_q || bus.firstin;
            lastout_d  = bus.lastin && !spill;
            tagout_d   = tag_d;
            pad_pend_d = spill;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FILL;
         blk_q        <= '0;
         lane_q       <= '0;
         first_pend_q <= 1'b0;
         pad_pend_q   <= 1'b0;
         firstout_q   <= 1'b0;
         lastout_q    <= 1'b0;
         tag_q        <= '0;
         tagout_q     <= '0;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         lane_q       <= lane_d;
         first_pend_q <= first_pend_d;
         pad_pend_q   <= pad_pend_d;
         firstout_q   <= firstout_d;
         lastout_q    <= lastout_d;
         tag_q        <= tag_d;
         tagout_q     <= tagout_d;
      end
   end
   assign bus.stopin   = state_q != FILL;
   assign bus.pushout  = state_q != FILL;
   assign bus.dout     = STATE_W'(blk_q);
   assign bus.firstout = firstout_q;
   assign bus.lastout  = lastout_q;
   assign bus.tagout   = tagout_q;
endmodule
